// File: rtl/timer_bank_pkg.sv
// rtl/timer_bank_pkg.sv - register map and bit positions shared by the timer bank.
package timer_bank_pkg;

  typedef enum logic [1:0] {
    REG_CTRL   = 2'd0,
    REG_PERIOD = 2'd1,
    REG_STATUS = 2'd2,
    REG_COUNT  = 2'd3
  } reg_e;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_ONESHOT = 1;
  localparam int CTRL_IE      = 2;
  localparam int STAT_TC      = 0;
  localparam int STAT_TOGGLE  = 2;

endpackage

// File: rtl/timer_channel.sv
// rtl/timer_channel.sv - one down-period timer channel; IE stored only with TIMER_BANK_IRQ_EN.
module timer_channel
  import timer_bank_pkg::*;
#(
  parameter int          WIDTH          = 32,
  parameter logic [31:0] DEFAULT_PERIOD = 32'h005F5E10,
  parameter logic        DEFAULT_EN     = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_ctrl,
  input  logic             wr_period,
  input  logic             wr_status,
  input  logic             wr_count,
  input  logic [WIDTH-1:0] wdata,
  output logic             en,
  output logic             oneshot,
  output logic             ie,
  output logic             tc,
  output logic             toggle,
  output logic             tick,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] period
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic             en_q, en_d, oneshot_q, oneshot_d;
  logic             tc_q, tc_d, toggle_q, toggle_d, tick_q, tick_d;
  logic [WIDTH-1:0] count_q, count_d, period_q, period_d;
  logic             fire;

  always_comb begin
    en_d      = en_q;
    oneshot_d = oneshot_q;
    tc_d      = tc_q;
    toggle_d  = toggle_q;
    tick_d    = 1'b0;
    count_d   = count_q;
    period_d  = period_q;
    fire      = 1'b0;

    if (wr_status && wdata[STAT_TC]) tc_d = 1'b0;

    // >= rather than == so a shrunk PERIOD fires immediately instead of wrapping
    if (en_q && (period_q != '0)) begin
      if (count_q >= period_q - ONE) begin
        fire     = 1'b1;
        count_d  = '0;
        tc_d     = 1'b1;
        toggle_d = ~toggle_q;
        tick_d   = 1'b1;
        if (oneshot_q) en_d = 1'b0;
      end else begin
        count_d = count_q + ONE;
      end
    end

    if (wr_period) period_d = wdata;
    if (wr_count)  count_d  = wdata;
    if (wr_ctrl) begin
      en_d      = wdata[CTRL_EN];
      oneshot_d = wdata[CTRL_ONESHOT];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_q      <= DEFAULT_EN;
      oneshot_q <= 1'b0;
      tc_q      <= 1'b0;
      toggle_q  <= 1'b0;
      tick_q    <= 1'b0;
      count_q   <= '0;
      period_q  <= WIDTH'(DEFAULT_PERIOD);
    end else begin
      en_q      <= en_d;
      oneshot_q <= oneshot_d;
      tc_q      <= tc_d;
      toggle_q  <= toggle_d;
      tick_q    <= tick_d;
      count_q   <= count_d;
      period_q  <= period_d;
    end
  end

`ifdef TIMER_BANK_IRQ_EN
  logic ie_q, ie_d;

  always_comb begin
    ie_d = ie_q;
    if (wr_ctrl) ie_d = wdata[CTRL_IE];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ie_q <= 1'b0;
    else       ie_q <= ie_d;
  end

  assign ie = ie_q;
`else
  assign ie = 1'b0;
`endif

  assign en      = en_q;
  assign oneshot = oneshot_q;
  assign tc      = tc_q;
  assign toggle  = toggle_q;
  assign tick    = tick_q;
  assign count   = count_q;
  assign period  = period_q;

endmodule

// File: rtl/timer_bank.sv
// rtl/timer_bank.sv - NCH timer channels behind one register port; irq live only with TIMER_BANK_IRQ_EN.
module timer_bank
  import timer_bank_pkg::*;
#(
  parameter int          NCH            = 4,
  parameter int          WIDTH          = 32,
  parameter logic [31:0] DEFAULT_PERIOD = 32'h005F5E10,
  parameter logic        DEFAULT_EN     = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [$clog2(NCH)+1:0]   addr,
  input  logic [WIDTH-1:0]         din,
  input  logic                     wren,
  input  logic                     rden,
  output logic [WIDTH-1:0]         dout,
  output logic [NCH-1:0]           tick,
  output logic [NCH-1:0]           toggle,
  output logic                     irq
);

  localparam int AW = $clog2(NCH) + 2;

  logic [AW-1:0]    ch_addr;
  reg_e             reg_sel;
  logic [NCH-1:0]   ch_en, ch_oneshot, ch_ie, ch_tc, ch_toggle, ch_tick;
  logic [WIDTH-1:0] ch_count  [NCH];
  logic [WIDTH-1:0] ch_period [NCH];
  logic [WIDTH-1:0] dout_q, dout_d;

  assign ch_addr = addr >> 2;
  assign reg_sel = reg_e'(addr[1:0]);

  // Channel addresses with no matching instance simply select nothing
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic sel;
    assign sel = wren && (ch_addr == AW'(i));

    timer_channel #(
      .WIDTH         (WIDTH),
      .DEFAULT_PERIOD(DEFAULT_PERIOD),
      .DEFAULT_EN    (DEFAULT_EN)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .wr_ctrl  (sel && (reg_sel == REG_CTRL)),
      .wr_period(sel && (reg_sel == REG_PERIOD)),
      .wr_status(sel && (reg_sel == REG_STATUS)),
      .wr_count (sel && (reg_sel == REG_COUNT)),
      .wdata    (din),
      .en       (ch_en[i]),
      .oneshot  (ch_oneshot[i]),
      .ie       (ch_ie[i]),
      .tc       (ch_tc[i]),
      .toggle   (ch_toggle[i]),
      .tick     (ch_tick[i]),
      .count    (ch_count[i]),
      .period   (ch_period[i])
    );
  end

  always_comb begin
    dout_d = dout_q;
    if (rden) begin
      dout_d = '0;
      for (int i = 0; i < NCH; i++) begin
        if (ch_addr == AW'(i)) begin
          case (reg_sel)
            REG_CTRL: begin
              dout_d[CTRL_EN]      = ch_en[i];
              dout_d[CTRL_ONESHOT] = ch_oneshot[i];
              dout_d[CTRL_IE]      = ch_ie[i];
            end
            REG_PERIOD: dout_d = ch_period[i];
            REG_STATUS: begin
              dout_d[STAT_TC]     = ch_tc[i];
              dout_d[STAT_TOGGLE] = ch_toggle[i];
            end
            REG_COUNT: dout_d = ch_count[i];
            default:   dout_d = '0;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) dout_q <= '0;
    else       dout_q <= dout_d;
  end

  assign dout   = dout_q;
  assign tick   = ch_tick;
  assign toggle = ch_toggle;

`ifdef TIMER_BANK_IRQ_EN
  assign irq = |(ch_tc & ch_ie);
`else
  assign irq = 1'b0;
`endif

endmodule
